apu_frame_counter: RTL and testbench



---
 rtl/apu_frame_counter.sv | 119 +++++++++++
 tb/tb_apu_frame_counter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_counter.sv
// NES APU frame sequencer: divides the CPU-cycle enable into quarter-frame
// and half-frame strobes, handles the $4017 mode/IRQ-inhibit write with its
// delayed sequencer reset, and keeps the frame IRQ flag read via $4015.
module apu_frame_counter #(
  parameter int STEP1 = 7457,
  parameter int STEP2 = 14913,
  parameter int STEP3 = 22371,
  parameter int STEP4 = 29829,
  parameter int STEP5 = 37281,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_ce,
  input  logic       wr_4017,
  input  logic [7:0] wr_data,
  input  logic       rd_4015,
  output logic       quarterframe,
  output logic       halfframe,
  output logic       frame_irq,
  output logic       mode,
  output logic       apu_phase
);

  localparam logic [CNT_W-1:0] S1   = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2   = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3   = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4   = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S4M1 = CNT_W'(STEP4 - 1);
  localparam logic [CNT_W-1:0] S5   = CNT_W'(STEP5);

  logic [CNT_W-1:0] cyc;
  logic             inhibit;
  logic             wrapped;
  logic [2:0]       rst_cnt;

  logic             mode_eff;
  logic             inh_eff;
  logic             expire;
  logic [CNT_W-1:0] last_cyc;
  logic             at_last;
  logic             irq_set;
  logic             unused_wr_bits;

  // Only the mode and inhibit bits of the $4017 write matter here.
  assign unused_wr_bits = ^wr_data[5:0];

  // A write takes effect on its own cpu_ce, so decode against the new mode/inhibit.
  always_comb begin
    mode_eff = wr_4017 ? wr_data[7] : mode;
    inh_eff  = wr_4017 ? wr_data[6] : inhibit;
    // Countdown reaches zero on this cpu_ce unless a fresh write restarts it.
    expire   = !wr_4017 && (rst_cnt == 3'd1);
    last_cyc = mode_eff ? S5 : S4;
    // >= also recovers if a 5-step -> 4-step switch leaves cyc past the end.
    at_last  = (cyc >= last_cyc);
    irq_set  = !expire && !mode_eff && !inh_eff &&
               ((cyc == S4M1) || (cyc == S4) || ((cyc == '0) && wrapped));
  end

  // Cycle counter, wrap marker and frame strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc          <= '0;
      wrapped      <= 1'b0;
      quarterframe <= 1'b0;
      halfframe    <= 1'b0;
    end else begin
      quarterframe <= 1'b0;
      halfframe    <= 1'b0;
      if (cpu_ce) begin
        if (expire) begin
          cyc          <= '0;
          wrapped      <= 1'b0;
          quarterframe <= mode;
          halfframe    <= mode;
        end else begin
          quarterframe <= (cyc == S1) || (cyc == S2) || (cyc == S3) || (cyc == last_cyc);
          halfframe    <= (cyc == S2) || (cyc == last_cyc);
          cyc          <= at_last ? '0 : cyc + CNT_W'(1);
          wrapped      <= !mode_eff && at_last;
        end
      end
    end
  end

  // $4017 control bits, delayed-reset countdown and CPU-cycle phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode      <= 1'b0;
      inhibit   <= 1'b0;
      rst_cnt   <= 3'd0;
      apu_phase <= 1'b0;
    end else if (cpu_ce) begin
      apu_phase <= ~apu_phase;
      if (wr_4017) begin
        mode    <= wr_data[7];
        inhibit <= wr_data[6];
        rst_cnt <= apu_phase ? 3'd4 : 3'd3;
      end else if (rst_cnt != 3'd0) begin
        rst_cnt <= rst_cnt - 3'd1;
      end
    end
  end

  // Frame IRQ flag: a set in the same cycle beats a $4015 read clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_irq <= 1'b0;
    end else if (cpu_ce) begin
      if (irq_set) begin
        frame_irq <= 1'b1;
      end else if (rd_4015 || (wr_4017 && wr_data[6])) begin
        frame_irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apu_frame_counter.sv
// Bench for apu_frame_counter, built with shortened frame steps so whole
// frames in both modes fit in a short run.
module tb_apu_frame_counter;

  localparam int P1 = 7;
  localparam int P2 = 14;
  localparam int P3 = 22;
  localparam int P4 = 29;
  localparam int P5 = 37;
  localparam int CW = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_ce = 1'b0;
  logic       wr_4017 = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_4015 = 1'b0;
  logic       quarterframe, halfframe, frame_irq, mode, apu_phase;

  always #5 clk = ~clk;

  apu_frame_counter #(
    .STEP1(P1), .STEP2(P2), .STEP3(P3), .STEP4(P4), .STEP5(P5), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .wr_4017(wr_4017), .wr_data(wr_data),
    .rd_4015(rd_4015), .quarterframe(quarterframe), .halfframe(halfframe),
    .frame_irq(frame_irq), .mode(mode), .apu_phase(apu_phase)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: position in frame, control bits, pending delay.
  int m_cyc;
  int m_cd;
  bit m_mode, m_inh, m_irq, m_phase, m_after_wrap, m_qf, m_hf;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_cd = 0; m_mode = 0; m_inh = 0; m_irq = 0;
    m_phase = 0; m_after_wrap = 0; m_qf = 0; m_hf = 0;
  endtask

  // One clock of the frame sequencer as described by its event rules.
  task automatic model_step(input bit r, input bit ce, input bit wr,
                            input bit [7:0] d, input bit rd);
    bit md, ih, fire, set;
    int last;
    if (r) begin
      model_reset();
      return;
    end
    m_qf = 0;
    m_hf = 0;
    if (!ce) return;
    md   = wr ? d[7] : m_mode;
    ih   = wr ? d[6] : m_inh;
    fire = !wr && (m_cd == 1);
    last = md ? P5 : P4;
    set  = 0;
    if (fire) begin
      m_qf = m_mode;
      m_hf = m_mode;
      m_cyc = 0;
      m_after_wrap = 0;
    end else begin
      m_qf = (m_cyc == P1) || (m_cyc == P2) || (m_cyc == P3) || (m_cyc == last);
      m_hf = (m_cyc == P2) || (m_cyc == last);
      set  = !md && !ih && ((m_cyc == P4 - 1) || (m_cyc == P4) || (m_cyc == 0 && m_after_wrap));
      m_after_wrap = !md && (m_cyc >= last);
      m_cyc = (m_cyc >= last) ? 0 : m_cyc + 1;
    end
    if (set) m_irq = 1;
    else if (rd || (wr && d[6])) m_irq = 0;
    m_cd = wr ? (m_phase ? 4 : 3) : ((m_cd > 0) ? m_cd - 1 : 0);
    m_mode = md;
    m_inh = ih;
    m_phase = ~m_phase;
  endtask

  function automatic int dut_vec();
    return int'({quarterframe, halfframe, frame_irq, mode, apu_phase});
  endfunction

  function automatic int model_vec();
    return int'({m_qf, m_hf, m_irq, m_mode, m_phase});
  endfunction

  // Drive one clock, advance the model, compare all outputs.
  task automatic step(input bit r, input bit ce, input bit wr,
                      input bit [7:0] d, input bit rd);
    rst = r; cpu_ce = ce; wr_4017 = wr; wr_data = d; rd_4015 = rd;
    @(posedge clk);
    model_step(r, ce, wr, d, rd);
    #1;
    rst = 0; cpu_ce = 0; wr_4017 = 0; rd_4015 = 0;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic tick();
    step(0, 1, 0, 8'h00, 0);
  endtask

  typedef struct {
    bit       ce;
    bit       wr;
    bit [7:0] d;
    bit [4:0] exp;  // {qf, hf, irq, mode, phase}
  } vec_t;

  vec_t tbl[12];

  initial begin
    int qf_n, hf_n, first_irq, seen_irq, gap, n;
    bit ph;

    model_reset();
    tbl[0]  = '{1, 1, 8'h80, 5'b00011};
    tbl[1]  = '{1, 0, 8'h00, 5'b00010};
    tbl[2]  = '{0, 1, 8'h00, 5'b00010};
    tbl[3]  = '{1, 0, 8'h00, 5'b00011};
    tbl[4]  = '{1, 0, 8'h00, 5'b11010};
    tbl[5]  = '{0, 0, 8'h00, 5'b00010};
    tbl[6]  = '{1, 0, 8'h00, 5'b00011};
    tbl[7]  = '{1, 1, 8'h80, 5'b00010};
    tbl[8]  = '{1, 0, 8'h00, 5'b00011};
    tbl[9]  = '{1, 0, 8'h00, 5'b00010};
    tbl[10] = '{1, 0, 8'h00, 5'b00011};
    tbl[11] = '{1, 0, 8'h00, 5'b11010};

    // Reset dominates a simultaneous write.
    step(1, 1, 1, 8'hC0, 1);
    step(1, 1, 0, 8'h00, 0);
    check("reset_state", dut_vec(), 0);

    // Write-delay vectors: phase 0 -> 3rd cpu_ce, phase 1 -> 4th cpu_ce.
    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].ce, tbl[i].wr, tbl[i].d, 0);
      check($sformatf("vec%0d", i), dut_vec(), int'(tbl[i].exp));
    end

    // Mode 0 free-run over two frames.
    step(1, 0, 0, 8'h00, 0);
    qf_n = 0; hf_n = 0; first_irq = -1;
    for (int i = 0; i < 2 * (P4 + 1); i++) begin
      int c;
      c = i % (P4 + 1);
      tick();
      check("m0_qf", int'(quarterframe), int'(c == P1 || c == P2 || c == P3 || c == P4));
      check("m0_hf", int'(halfframe), int'(c == P2 || c == P4));
      if (i < P4 + 1) begin
        qf_n += int'(quarterframe);
        hf_n += int'(halfframe);
      end
      if (frame_irq && first_irq < 0) first_irq = i;
    end
    check("m0_qf_count", qf_n, 4);
    check("m0_hf_count", hf_n, 2);
    check("m0_irq_rise", first_irq, P4 - 1);

    // $4015 read early in the third frame clears the flag.
    for (int c = 0; c < 5; c++) tick();
    check("irq_before_rd", int'(frame_irq), 1);
    step(0, 1, 0, 8'h00, 1);
    check("rd_clear", int'(frame_irq), 0);

    // Read coinciding with the STEP4 set cycle: set wins.
    for (int c = 6; c < P4; c++) tick();
    step(0, 1, 0, 8'h00, 1);
    check("rd_vs_set", int'(frame_irq), 1);

    // Inhibit write clears the flag at once and blocks further sets.
    step(0, 1, 1, 8'h40, 0);
    check("inhibit_clear", int'(frame_irq), 0);
    seen_irq = 0;
    for (int i = 0; i < 2 * (P4 + 1); i++) begin
      tick();
      seen_irq |= int'(frame_irq);
    end
    check("inhibit_hold", seen_irq, 0);

    // Mode 1: expiry strobe, then one full 5-step frame.
    ph = apu_phase;
    step(0, 1, 1, 8'h80, 0);
    for (int i = 0; i < (ph ? 4 : 3); i++) tick();
    check("m1_expiry", int'({quarterframe, halfframe}), 3);
    qf_n = 0; hf_n = 0; seen_irq = 0;
    for (int c = 0; c <= P5; c++) begin
      tick();
      check("m1_qf", int'(quarterframe), int'(c == P1 || c == P2 || c == P3 || c == P5));
      qf_n += int'(quarterframe);
      hf_n += int'(halfframe);
      seen_irq |= int'(frame_irq);
    end
    check("m1_qf_count", qf_n, 4);
    check("m1_hf_count", hf_n, 2);
    check("m1_no_irq", seen_irq, 0);

    // Back-to-back writes: only the second one's reset happens.
    step(0, 1, 1, 8'h80, 0);
    tick();
    ph = apu_phase;
    step(0, 1, 1, 8'h00, 0);
    gap = -1;
    n = 0;
    for (int i = 1; i <= 4 * P5 && gap < 0; i++) begin
      tick();
      if (i <= 4) n += int'(quarterframe | halfframe);
      if (quarterframe) gap = i;
    end
    check("b2b_no_strobe", n, 0);
    check("b2b_mode", int'(mode), 0);
    check("b2b_gap", gap, (ph ? 4 : 3) + P1 + 1);

    // Reset mid-frame with a countdown pending.
    for (int i = 0; i < 10; i++) tick();
    step(0, 1, 1, 8'h80, 0);
    tick();
    step(1, 1, 0, 8'h00, 0);
    check("rst_mid", dut_vec(), 0);
    gap = -1;
    for (int i = 1; i <= 4 * P5 && gap < 0; i++) begin
      tick();
      if (quarterframe) gap = i;
    end
    check("rst_mid_first_qf", gap, P1 + 1);
    check("rst_mid_mode", int'(mode), 0);

    // Random traffic against the model.
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4000; i++) begin
      bit r, ce, wr, rd;
      bit [7:0] d;
      r  = ($urandom_range(0, 999) < 2);
      ce = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 99) < 2);
      rd = ($urandom_range(0, 99) < 5);
      d  = 8'($urandom);
      step(r, ce, wr, d, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
